ps2_receptor: RTL and testbench

PS2_RECEPTOR -- requirements
Module: ps2_receptor

---
 rtl/ps2_receptor.sv | 194 +++++++++++++++++++
 tb/tb_ps2_receptor.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ps2_receptor.sv
// rtl/ps2_receptor.sv - PS/2 keyboard frame receiver with make/break tracking
//
// Receives 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop)
// and tracks the key currently held.
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   ps2c, ps2d   : PS/2 clock and data, asynchronous to clk
//   code_o       : scan code of the held key, 0x00 when none is held
//   scan_valid_o : one-cycle pulse per accepted non-prefix byte
//   break_o      : qualifies scan_valid_o (1 = release, 0 = press)
//   err_o        : one-cycle pulse on a discarded frame or timeout
// Optional feature: define PS2_PARITY_CHECK_EN to reject frames with bad parity.
module ps2_receptor #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] code_o,
    output logic       scan_valid_o,
    output logic       break_o,
    output logic       err_o
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_c_meta, r_c_sync, r_d_meta, r_d_sync;
    logic        r_filt, r_filt_d;
    logic [FW-1:0] r_fcnt;
    logic [TW-1:0] r_to_cnt;
    logic [2:0]  r_bitcnt;
    logic [7:0]  r_shift;
    logic        r_par;
    logic        r_brk, r_ext;

    logic w_fall, w_timeout, w_par_bad, w_is_f0, w_is_e0;
    logic w_start, w_shift_en, w_par_en, w_stop, w_accept, w_frame_err;

    // Two-flop synchronizers; reset to 1 because the idle bus is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_meta <= 1'b1;
            r_c_sync <= 1'b1;
            r_d_meta <= 1'b1;
            r_d_sync <= 1'b1;
        end else begin
            r_c_meta <= ps2c;
            r_c_sync <= r_c_meta;
            r_d_meta <= ps2d;
            r_d_sync <= r_d_meta;
        end
    end

    // Glitch filter: counts consecutive samples that disagree with the
    // filtered level; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt   <= 1'b1;
            r_filt_d <= 1'b1;
            r_fcnt   <= '0;
        end else begin
            r_filt_d <= r_filt;
            if (r_c_sync == r_filt) begin
                r_fcnt <= '0;
            end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
                r_filt <= r_c_sync;
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    assign w_fall    = r_filt_d & ~r_filt;
    assign w_timeout = (r_state != IDLE) && !w_fall &&
                       (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_is_f0   = (r_shift == 8'hF0);
    assign w_is_e0   = (r_shift == 8'hE0);

`ifdef PS2_PARITY_CHECK_EN
    // Odd parity: data plus parity bit must have odd weight.
    assign w_par_bad = ~(^{r_shift, r_par});
`else
    assign w_par_bad = 1'b0;
`endif

    // Inter-edge timeout counter, idle-held at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_to_cnt <= '0;
        else if (r_state == IDLE || w_fall)
            r_to_cnt <= '0;
        else
            r_to_cnt <= r_to_cnt + 1'b1;
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        if (w_timeout) begin
            w_next = IDLE;
        end else if (w_fall) begin
            case (r_state)
                IDLE:    w_next = r_d_sync ? IDLE : DATA;
                DATA:    w_next = (r_bitcnt == 3'd7) ? PARITY : DATA;
                PARITY:  w_next = STOP;
                default: w_next = IDLE;
            endcase
        end
    end

    // FSM: decoded actions
    always_comb begin
        w_start     = (r_state == IDLE)   && w_fall && !r_d_sync;
        w_shift_en  = (r_state == DATA)   && w_fall;
        w_par_en    = (r_state == PARITY) && w_fall;
        w_stop      = (r_state == STOP)   && w_fall;
        w_accept    = w_stop && r_d_sync && !w_par_bad;
        w_frame_err = w_timeout || (w_stop && (!r_d_sync || w_par_bad));
    end

    // Frame datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
        end else begin
            if (w_timeout) begin
                r_bitcnt <= '0;
                r_shift  <= '0;
            end else if (w_start) begin
                r_bitcnt <= '0;
            end else if (w_shift_en) begin
                r_bitcnt <= r_bitcnt + 1'b1;
                r_shift  <= {r_d_sync, r_shift[7:1]};
            end
            r_par <= w_par_en ? r_d_sync : r_par;
        end
    end

    // Extended-prefix flag: set by E0, cleared by the next real byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ext <= 1'b0;
        else
            r_ext <= w_timeout                 ? 1'b0 :
                     (w_accept && w_is_e0)      ? 1'b1 :
                     (w_accept && !w_is_f0)     ? 1'b0 : r_ext;
    end

    // Event outputs and held-key tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_o       <= 8'h00;
            scan_valid_o <= 1'b0;
            break_o      <= 1'b0;
            err_o        <= 1'b0;
            r_brk        <= 1'b0;
        end else begin
            scan_valid_o <= 1'b0;
            err_o        <= w_frame_err;
            if (w_timeout) begin
                r_brk <= 1'b0;
            end else if (w_accept) begin
                if (w_is_f0) begin
                    r_brk <= 1'b1;
                end else if (!w_is_e0) begin
                    scan_valid_o <= 1'b1;
                    break_o      <= r_brk;
                    r_brk        <= 1'b0;
                    if (!r_brk)
                        code_o <= r_shift;
                    else if (r_shift == code_o)
                        code_o <= 8'h00;
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_receptor.sv
// tb/tb_ps2_receptor.sv - directed bench for ps2_receptor
module tb_ps2_receptor;
    // PS/2 timing scaled so a bit period is 80 clk cycles and the timeout
    // spans 20 bit periods, matching 10 kHz vs 2 ms at 50 MHz.
    localparam int HALF  = 40;
    localparam int TO    = 1600;
    localparam int STALL = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic [7:0] code_o;
    logic       scan_valid_o, break_o, err_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_valid = 0;
    int n_err   = 0;
    int v0, e0;

    ps2_receptor #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ps2c(ps2c), .ps2d(ps2d),
        .code_o(code_o), .scan_valid_o(scan_valid_o),
        .break_o(break_o), .err_o(err_o)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (scan_valid_o) n_valid++;
        if (err_o)        n_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One PS/2 bit; optional 3-cycle glitches inside each half period.
    task automatic send_bit(input logic b, input bit glitch);
        ps2d = b;
        if (glitch) begin
            wait_cyc(15); ps2c = 1'b0; wait_cyc(3); ps2c = 1'b1; wait_cyc(HALF - 18);
        end else begin
            wait_cyc(HALF);
        end
        ps2c = 1'b0;
        if (glitch) begin
            wait_cyc(15); ps2c = 1'b1; wait_cyc(3); ps2c = 1'b0; wait_cyc(HALF - 18);
        end else begin
            wait_cyc(HALF);
        end
        ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic p, input bit glitch);
        send_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
        send_bit(p, glitch);
        send_bit(1'b1, glitch);
        ps2d = 1'b1;
        wait_cyc(30);
    endtask

    initial begin
        wait_cyc(5);
        check("rst_code",  {24'd0, code_o}, 32'h00);
        check("rst_valid", {31'd0, scan_valid_o}, 32'd0);
        check("rst_break", {31'd0, break_o}, 32'd0);
        check("rst_err",   {31'd0, err_o}, 32'd0);
        rst_n = 1'b1;
        wait_cyc(20);

        // Press 0x1C
        v0 = n_valid; e0 = n_err;
        send_frame(8'h1C, 1'b0, 1'b0);
        check("press_pulses", n_valid - v0, 1);
        check("press_break",  {31'd0, break_o}, 32'd0);
        check("press_code",   {24'd0, code_o}, 32'h1C);
        check("press_err",    n_err - e0, 0);

        // Release 0x1C
        v0 = n_valid;
        send_frame(8'hF0, 1'b1, 1'b0);
        check("f0_no_pulse", n_valid - v0, 0);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("rel_pulses", n_valid - v0, 1);
        check("rel_break",  {31'd0, break_o}, 32'd1);
        check("rel_code",   {24'd0, code_o}, 32'h00);

        // Hold 0x1B, release a different key 0x23
        send_frame(8'h1B, 1'b1, 1'b0);
        check("hold_code",  {24'd0, code_o}, 32'h1B);
        check("hold_break", {31'd0, break_o}, 32'd0);
        v0 = n_valid;
        send_frame(8'hF0, 1'b1, 1'b0);
        send_frame(8'h23, 1'b0, 1'b0);
        check("other_pulses", n_valid - v0, 1);
        check("other_break",  {31'd0, break_o}, 32'd1);
        check("other_code",   {24'd0, code_o}, 32'h1B);

        // 0x1C with wrong parity
        v0 = n_valid; e0 = n_err;
        send_frame(8'h1C, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        check("par_err",    n_err - e0, 1);
        check("par_pulses", n_valid - v0, 0);
        check("par_code",   {24'd0, code_o}, 32'h1B);
`else
        check("par_err",    n_err - e0, 0);
        check("par_pulses", n_valid - v0, 1);
        check("par_code",   {24'd0, code_o}, 32'h1C);
`endif

        // Timeout: start + 4 data bits, then stall
        v0 = n_valid; e0 = n_err;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        ps2d = 1'b1;
        wait_cyc(STALL);
        check("to_err",    n_err - e0, 1);
        check("to_pulses", n_valid - v0, 0);
        send_frame(8'h2B, 1'b1, 1'b0);
        check("to_after_code",   {24'd0, code_o}, 32'h2B);
        check("to_after_pulses", n_valid - v0, 1);
        check("to_after_err",    n_err - e0, 1);

        // Glitched E0 1C
        v0 = n_valid; e0 = n_err;
        send_frame(8'hE0, 1'b0, 1'b1);
        check("gl_e0_no_pulse", n_valid - v0, 0);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("gl_pulses", n_valid - v0, 1);
        check("gl_break",  {31'd0, break_o}, 32'd0);
        check("gl_code",   {24'd0, code_o}, 32'h1C);
        check("gl_err",    n_err - e0, 0);

        // Reset returns held code to zero
        rst_n = 1'b0;
        wait_cyc(3);
        check("rst2_code", {24'd0, code_o}, 32'h00);
        rst_n = 1'b1;
        wait_cyc(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
